hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32: number of architectural registers tracked.
REQ-002 Parameter ADDR_W, default 5: register address width; the block SHALL satisfy 2**ADDR_W >= NUM_REGS.
REQ-003 Parameter LAT_W, default 3: countdown width; every latency parameter SHALL be < 2**LAT_W.
REQ-004 Parameter LOAD_LAT, default 2: cycles until load data is forwardable.
REQ-005 Parameter MUL_LAT, default 3: cycles until multiply result is forwardable.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 id_rs1_addr, id_rs2_addr  in  ADDR_W each  source registers of the instruction in ID.
REQ-010 id_rs1_used, id_rs2_used  in  1 each  the source is actually read.
REQ-011 issue_valid  in  1  the instruction in ID requests to advance to EX this cycle.
REQ-012 issue_rd_addr  in  ADDR_W  destination of the issuing instruction.
REQ-013 issue_class  in  2  0=ALU, 1=LOAD, 2=MUL, 3=no writeback.
REQ-014 flush  in  1  squash the instruction currently in EX and the one in ID.
REQ-015 pipeline_stall  out  1  hold PC and IF/ID, bubble ID/EX.
REQ-016 busy_vec  out  NUM_REGS  bit r is high when cnt[r] != 0.
REQ-017 stall_count  out  16  saturating count of stall cycles.

Function
REQ-018 The block SHALL hold a LAT_W-bit countdown cnt[r] for every register r; cnt[0] SHALL stay 0.
REQ-019 An accepted issue (issue_valid & !pipeline_stall & !flush & rd!=0 & class!=3) SHALL load cnt[rd] with 1 for ALU, LOAD_LAT for LOAD, and MUL_LAT for MUL.
REQ-020 Each cycle, every nonzero cnt[r] not being loaded SHALL decrement by 1; a load SHALL take priority over the decrement on the same register.
REQ-021 The stall threshold SHALL be TH=1 with forwarding and TH=0 without forwarding (see REQ-031).
REQ-022 pipeline_stall SHALL be combinational from the registered counters: (id_rs1_used & rs1!=0 & cnt[rs1]>TH) | (id_rs2_used & rs2!=0 & cnt[rs2]>TH).
REQ-023 pipeline_stall SHALL be forced to 0 while flush is high.
REQ-024 The block SHALL register the last accepted issue (last_rd, last_valid); last_valid SHALL clear on any cycle without an accepted issue.
REQ-025 flush with last_valid SHALL clear cnt[last_rd] to 0, overriding decrement; flush SHALL block issue in the same cycle.
REQ-026 stall_count SHALL increment on each cycle with pipeline_stall=1 and saturate at 16'hFFFF.
REQ-027 The timing SHALL be: producer issued at cycle t makes cnt=L visible at t+1, so load-use with forwarding costs exactly LOAD_LAT-1 bubbles.

Reset
REQ-028 rst SHALL immediately clear all cnt[], last_valid, and stall_count; busy_vec=0 and pipeline_stall=0 while rst is high.
REQ-029 Reset asserted mid-countdown SHALL discard all pending state; no stall SHALL follow deassertion.
REQ-030 Inputs SHALL be ignored while rst is high.

Configuration
REQ-031 Macro HAZARD_FWD_EN: defined gives TH=1 (EX/MEM bypass present); undefined gives TH=0, so the consumer stalls until the counter reaches 0 and ALU-ALU dependences cost 1 bubble.

Structure
REQ-032 Package hazard_pkg SHALL hold the issue_class encodings (CLS_ALU, CLS_LOAD, CLS_MUL, CLS_NONE) and the default latency constants.
REQ-033 The per-register countdown SHALL be the sub-module hazard_reg_counter (load, decrement, clear, busy), instantiated in a generate loop for r=1..NUM_REGS-1.

Verification
REQ-034 Scenario LOAD x5 issued, next ID reads rs1=5 with FWD: pipeline_stall=1 for exactly 1 cycle, then 0; stall_count=1.
REQ-035 Scenario MUL x7 (MUL_LAT=3), then a consumer of x7: 2 stall cycles with FWD, 3 without; busy_vec[7] high for 3 cycles.
REQ-036 Scenario ALU x3 followed by a consumer: 0 stalls with FWD, 1 stall without.
REQ-037 Scenario LOAD x9 then flush next cycle: cnt[9]=0, busy_vec[9]=0, a subsequent reader of x9 sees no stall.
REQ-038 Scenario LOAD x0 and a reader of x0: no stall, busy_vec=0.
REQ-039 Scenario rst pulsed while MUL x4 cnt=2: busy_vec=0 immediately; after release a reader of x4 sees no stall; forcing stalls for 70000 cycles leaves stall_count=16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings and default latencies for the register hazard scoreboard.
package hazard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_NONE = 2'd3
    } issue_class_e;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_LAT_W    = 3;
    localparam int DEF_LOAD_LAT = 2;
    localparam int DEF_MUL_LAT  = 3;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_reg_counter.sv
// Per-register result countdown: a clear beats a load, and a load beats the
// normal decrement toward zero.
module hazard_reg_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             clear_i,
    output logic [LAT_W-1:0] cnt_o,
    output logic             busy_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard producing the ID-stage interlock stall.
// Build option: define HAZARD_FWD_EN when the EX/MEM bypass exists (stall threshold 1 instead of 0).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LAT_W    = DEF_LAT_W,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   id_rs1_addr,
    input  logic [ADDR_W-1:0]   id_rs2_addr,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd_addr,
    input  logic [1:0]          issue_class,
    input  logic                flush,
    output logic                pipeline_stall,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [15:0]         stall_count
);

`ifdef HAZARD_FWD_EN
    localparam int STALL_TH = 1;
`else
    localparam int STALL_TH = 0;
`endif

    logic [LAT_W-1:0]  cnt [NUM_REGS];
    logic [LAT_W-1:0]  issue_lat;
    logic [LAT_W-1:0]  rs1_cnt;
    logic [LAT_W-1:0]  rs2_cnt;
    logic              rs1_hazard;
    logic              rs2_hazard;
    logic              issue_accept;
    logic              last_valid_q;
    logic [ADDR_W-1:0] last_rd_q;
    logic [15:0]       stall_count_q;

    always_comb begin
        issue_lat = '0;
        case (issue_class_e'(issue_class))
            CLS_ALU:  issue_lat = LAT_W'(1);
            CLS_LOAD: issue_lat = LAT_W'(LOAD_LAT);
            CLS_MUL:  issue_lat = LAT_W'(MUL_LAT);
            default:  issue_lat = '0;
        endcase
    end

    assign rs1_cnt    = cnt[id_rs1_addr];
    assign rs2_cnt    = cnt[id_rs2_addr];
    assign rs1_hazard = id_rs1_used && (id_rs1_addr != '0) && (rs1_cnt > LAT_W'(STALL_TH));
    assign rs2_hazard = id_rs2_used && (id_rs2_addr != '0) && (rs2_cnt > LAT_W'(STALL_TH));

    // A flush squashes the ID instruction, so it can never be held back.
    assign pipeline_stall = !flush && (rs1_hazard || rs2_hazard);

    assign issue_accept = issue_valid && !pipeline_stall && !flush &&
                          (issue_rd_addr != '0) &&
                          (issue_class_e'(issue_class) != CLS_NONE);

    assign cnt[0]      = '0;
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        hazard_reg_counter #(
            .LAT_W (LAT_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .load_i     (issue_accept && (issue_rd_addr == ADDR_W'(r))),
            .load_val_i (issue_lat),
            .clear_i    (flush && last_valid_q && (last_rd_q == ADDR_W'(r))),
            .cnt_o      (cnt[r]),
            .busy_o     (busy_vec[r])
        );
    end

    // Tracks the producer now in EX so a flush can retract its reservation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_valid_q <= 1'b0;
            last_rd_q    <= '0;
        end else begin
            last_valid_q <= issue_accept;
            if (issue_accept) begin
                last_rd_q <= issue_rd_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (pipeline_stall && (stall_count_q != STALL_CNT_MAX)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed checks of hazard_scoreboard against a behavioural model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam int TH = 1;
`else
    localparam int TH = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, issue_rd_addr;
    logic        id_rs1_used, id_rs2_used, issue_valid, flush;
    logic [1:0]  issue_class;
    logic        pipeline_stall;
    logic [31:0] busy_vec;
    logic [15:0] stall_count;

    logic        s_rst;
    logic [1:0]  s_rs1_addr, s_rs2_addr, s_rd_addr;
    logic        s_rs1_used, s_rs2_used, s_issue_valid, s_flush;
    logic [1:0]  s_class;
    logic        s_stall;
    logic [3:0]  s_busy;
    logic [15:0] s_count;

    int errors = 0;
    int checks = 0;

    int cnt_m [32];
    bit last_valid_m;
    int last_rd_m;
    int sc_m;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .issue_valid    (issue_valid),
        .issue_rd_addr  (issue_rd_addr),
        .issue_class    (issue_class),
        .flush          (flush),
        .pipeline_stall (pipeline_stall),
        .busy_vec       (busy_vec),
        .stall_count    (stall_count)
    );

    // Long MUL latency so the stall counter can be driven into saturation.
    hazard_scoreboard #(
        .NUM_REGS (4),
        .ADDR_W   (2),
        .LAT_W    (6),
        .LOAD_LAT (2),
        .MUL_LAT  (63)
    ) dut_sat (
        .clk            (clk),
        .rst            (s_rst),
        .id_rs1_addr    (s_rs1_addr),
        .id_rs2_addr    (s_rs2_addr),
        .id_rs1_used    (s_rs1_used),
        .id_rs2_used    (s_rs2_used),
        .issue_valid    (s_issue_valid),
        .issue_rd_addr  (s_rd_addr),
        .issue_class    (s_class),
        .flush          (s_flush),
        .pipeline_stall (s_stall),
        .busy_vec       (s_busy),
        .stall_count    (s_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        last_valid_m = 1'b0;
        last_rd_m    = 0;
        sc_m         = 0;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int r = 0; r < 32; r++) b[r] = (cnt_m[r] != 0);
        return b;
    endfunction

    function automatic int class_lat(input logic [1:0] cls);
        case (cls)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 3;
            default: return 0;
        endcase
    endfunction

    // One pipeline cycle: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input logic u1, input logic [4:0] a1, input logic u2, input logic [4:0] a2,
                         input logic iv, input logic [4:0] rd, input logic [1:0] cls, input logic fl,
                         output logic st);
        bit exp_st;
        bit acc;
        id_rs1_used = u1; id_rs1_addr = a1;
        id_rs2_used = u2; id_rs2_addr = a2;
        issue_valid = iv; issue_rd_addr = rd; issue_class = cls; flush = fl;
        #1;
        exp_st = !fl && ((u1 && a1 != 0 && cnt_m[a1] > TH) || (u2 && a2 != 0 && cnt_m[a2] > TH));
        check_val("stall", {31'd0, pipeline_stall}, {31'd0, exp_st});
        check_val("busy_vec", busy_vec, model_busy());
        check_val("stall_count", {16'd0, stall_count}, sc_m);
        st = pipeline_stall;
        @(posedge clk);
        acc = iv && !exp_st && !fl && rd != 0 && cls != 2'd3;
        for (int r = 1; r < 32; r++) begin
            if (fl && last_valid_m && r == last_rd_m) cnt_m[r] = 0;
            else if (acc && r == int'(rd))          cnt_m[r] = class_lat(cls);
            else if (cnt_m[r] > 0)                  cnt_m[r]--;
        end
        last_valid_m = acc;
        if (acc) last_rd_m = int'(rd);
        if (exp_st && sc_m < 65535) sc_m++;
        @(negedge clk);
    endtask

    task automatic idle();
        logic st;
        cycle(0, 0, 0, 0, 0, 0, 2'd3, 0, st);
    endtask

    task automatic consume(input logic [4:0] a, output int n);
        logic st;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, a, 0, 0, 1, 0, CLS_NONE, 0, st);
            if (st) n++;
            else break;
        end
    endtask

    initial begin
        logic st;
        int n;
        rst = 1'b1; s_rst = 1'b1;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
        issue_valid = 0; issue_rd_addr = 0; issue_class = 0; flush = 0;
        s_rs1_addr = 0; s_rs2_addr = 0; s_rs1_used = 0; s_rs2_used = 0;
        s_issue_valid = 0; s_rd_addr = 0; s_class = 0; s_flush = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy_vec, 0);
        check_val("rst_stall", {31'd0, pipeline_stall}, 0);
        check_val("rst_count", {16'd0, stall_count}, 0);
        rst = 1'b0;
        idle();

        // load-use
        cycle(0, 0, 0, 0, 1, 5, CLS_LOAD, 0, st);
        consume(5, n);
        check_val("load_use_stalls", n, (TH == 1) ? 1 : 2);
        check_val("load_use_count", {16'd0, stall_count}, (TH == 1) ? 1 : 2);
        repeat (3) idle();

        // MUL busy window, then MUL-use
        cycle(0, 0, 0, 0, 1, 7, CLS_MUL, 0, st);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy_vec[7]) n++;
            idle();
        end
        check_val("mul_busy_cycles", n, 3);
        cycle(0, 0, 0, 0, 1, 7, CLS_MUL, 0, st);
        consume(7, n);
        check_val("mul_use_stalls", n, (TH == 1) ? 2 : 3);
        repeat (3) idle();

        // ALU-use, on rs2
        cycle(0, 0, 0, 0, 1, 3, CLS_ALU, 0, st);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 3, 1, 0, CLS_NONE, 0, st);
            if (st) n++;
            else break;
        end
        check_val("alu_use_stalls", n, (TH == 1) ? 0 : 1);
        repeat (3) idle();

        // flush retracts the load in EX and blocks the flushed-cycle issue
        cycle(0, 0, 0, 0, 1, 9, CLS_LOAD, 0, st);
        cycle(1, 9, 0, 0, 1, 10, CLS_ALU, 1, st);
        check_val("flush_stall", {31'd0, st}, 0);
        check_val("flush_busy9", {31'd0, busy_vec[9]}, 0);
        check_val("flush_busy10", {31'd0, busy_vec[10]}, 0);
        consume(9, n);
        check_val("flush_reader", n, 0);

        // x0 never reserved
        cycle(0, 0, 0, 0, 1, 0, CLS_LOAD, 0, st);
        check_val("x0_busy", busy_vec, 0);
        consume(0, n);
        check_val("x0_reader", n, 0);

        // reset mid-countdown
        cycle(0, 0, 0, 0, 1, 4, CLS_MUL, 0, st);
        idle();
        id_rs1_used = 1; id_rs1_addr = 4;
        rst = 1'b1;
        #1;
        check_val("midrst_busy", busy_vec, 0);
        check_val("midrst_stall", {31'd0, pipeline_stall}, 0);
        check_val("midrst_count", {16'd0, stall_count}, 0);
        model_reset();
        issue_valid = 1; issue_rd_addr = 6; issue_class = CLS_ALU; id_rs1_used = 0;
        @(negedge clk);
        rst = 1'b0;
        consume(4, n);
        check_val("postrst_reader", n, 0);
        check_val("postrst_busy", busy_vec, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0), st);
        end

        // stall counter saturation on the long-latency instance
        s_rst = 1'b0;
        s_issue_valid = 1; s_rd_addr = 1; s_class = CLS_MUL;
        s_rs1_used = 1; s_rs1_addr = 1;
        repeat (10) @(negedge clk);
        s_rst = 1'b1;
        #1;
        check_val("sat_rst_busy", {28'd0, s_busy}, 0);
        check_val("sat_rst_stall", {31'd0, s_stall}, 0);
        @(negedge clk);
        s_rst = 1'b0;
        #1;
        check_val("sat_release_stall", {31'd0, s_stall}, 0);
        repeat (70000) @(negedge clk);
        check_val("sat_count", {16'd0, s_count}, 32'h0000FFFF);
        repeat (100) @(negedge clk);
        check_val("sat_hold", {16'd0, s_count}, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
